// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and scan-state type for the 7-segment scan controller
package seg_pkg;

    localparam int         DIGIT_W   = 4;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - hex nibble to active-low 7-segment pattern (bit6 = g, bit0 = a)
module hex_to_seg (
    input  logic       i_rst,
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'b1111111;
        if (!i_rst) begin
            case (i_hex)
                4'h0: o_seg = 7'b1000000;
                4'h1: o_seg = 7'b1111001;
                4'h2: o_seg = 7'b0100100;
                4'h3: o_seg = 7'b0110000;
                4'h4: o_seg = 7'b0011001;
                4'h5: o_seg = 7'b0010010;
                4'h6: o_seg = 7'b0000010;
                4'h7: o_seg = 7'b1111000;
                4'h8: o_seg = 7'b0000000;
                4'h9: o_seg = 7'b0010000;
                4'hA: o_seg = 7'b0001000;
                4'hB: o_seg = 7'b0000011;
                4'hC: o_seg = 7'b1000110;
                4'hD: o_seg = 7'b0100001;
                4'hE: o_seg = 7'b0000110;
                default: o_seg = 7'b0001110;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed common-anode display scanner with frame-aligned value updates
// Optional leading-zero blanking when SEG_LZ_BLANK_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] data_in,
    input  logic                          load_valid,
    output logic                          load_ready,
    output logic [6:0]                    seg_out,
    output logic [NUM_DIGITS-1:0]         an_out,
    output logic                          frame_done
);

    localparam int MAXC = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW   = DIGIT_W * NUM_DIGITS;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    scan_state_t             r_state, w_state_nxt;
    logic [CW-1:0]           r_cnt, w_cnt_nxt;
    logic [IW-1:0]           r_idx, w_idx_nxt;
    logic [DW-1:0]           r_shadow, r_pending, w_shadow_nxt;
    logic                    r_pending_flag;
    logic                    w_boundary, w_wrap, w_accept;
    logic [DIGIT_W-1:0]      w_dec_hex;
    logic [6:0]              w_dec_seg;
    logic                    w_digit_shown;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic [6:0]              w_seg_nxt;
    logic                    w_fd_nxt;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_boundary  = 1'b0;
        w_wrap      = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nxt = BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_boundary  = 1'b1;
                end
            end
            BLANK: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else if (r_cnt == BLANK_LAST) begin
                    w_state_nxt = SHOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            SHOW: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else if (r_cnt == SHOW_LAST) begin
                    w_state_nxt = BLANK;
                    w_cnt_nxt   = '0;
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt  = '0;
                        w_wrap     = 1'b1;
                        w_boundary = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Decode from next-cycle shadow/idx so seg_out is valid on the very first BLANK cycle.
    assign w_accept     = load_valid && load_ready;
    assign w_shadow_nxt = (w_boundary && r_pending_flag) ? r_pending : r_shadow;
    assign w_dec_hex    = w_shadow_nxt[w_idx_nxt*DIGIT_W +: DIGIT_W];

    hex_to_seg u_hex_to_seg (
        .i_rst (1'b0),
        .i_hex (w_dec_hex),
        .o_seg (w_dec_seg)
    );

`ifdef SEG_LZ_BLANK_EN
    logic [IW-1:0] w_msd;

    always_comb begin
        w_msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (w_shadow_nxt[i*DIGIT_W +: DIGIT_W] != '0) w_msd = IW'(i);
        end
    end

    assign w_digit_shown = (w_idx_nxt <= w_msd);
`else
    assign w_digit_shown = 1'b1;
`endif

    always_comb begin
        w_an_nxt  = '1;
        w_seg_nxt = SEG_BLANK;
        w_fd_nxt  = w_wrap;
        if (w_state_nxt != IDLE && w_digit_shown) begin
            w_seg_nxt = w_dec_seg;
            if (w_state_nxt == SHOW) w_an_nxt = ~(NUM_DIGITS'(1) << w_idx_nxt);
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            an_out     <= '1;
            seg_out    <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            an_out     <= w_an_nxt;
            seg_out    <= w_seg_nxt;
            frame_done <= w_fd_nxt;
        end
    end

    // A load arriving on a boundary cycle always has pending_flag clear, so it waits a full frame.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_shadow       <= '0;
            r_pending      <= '0;
            r_pending_flag <= 1'b0;
            load_ready     <= 1'b1;
        end else begin
            r_shadow <= w_shadow_nxt;
            if (w_boundary && r_pending_flag) begin
                r_pending_flag <= 1'b0;
                load_ready     <= 1'b1;
            end
            if (w_accept) begin
                r_pending      <= data_in;
                r_pending_flag <= 1'b1;
                load_ready     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized bench for seg_scan_ctrl against a frame-position reference model
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int P     = 8;
    localparam int B     = 2;
    localparam int SLOT  = P + B;
    localparam int FRAME = ND * SLOT;

    logic        clk_in     = 1'b0;
    logic        rst        = 1'b0;
    logic        enable     = 1'b0;
    logic [15:0] data_in    = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [6:0]  seg_out;
    logic [3:0]  an_out;
    logic        frame_done;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (P),
        .BLANK_CYCLES (B)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .enable     (enable),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 clk_in = ~clk_in;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: scan position is just cycles elapsed since the scan started.
    logic [15:0] m_shadow, m_pending;
    logic        m_flag, m_ready, m_running;
    int          m_t;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_shadow  = '0;
        m_pending = '0;
        m_flag    = 1'b0;
        m_ready   = 1'b1;
        m_running = 1'b0;
        m_t       = 0;
    endtask

    task automatic model_step();
        bit acc;
        bit bnd;
        acc = load_valid && m_ready;
        bnd = 1'b0;
        if (!enable) begin
            m_running = 1'b0;
            m_t       = 0;
        end else if (!m_running) begin
            m_running = 1'b1;
            m_t       = 0;
            bnd       = 1'b1;
        end else begin
            m_t++;
            bnd = (m_t % FRAME == 0);
        end
        if (bnd && m_flag) begin
            m_shadow = m_pending;
            m_flag   = 1'b0;
            m_ready  = 1'b1;
        end
        if (acc) begin
            m_pending = data_in;
            m_flag    = 1'b1;
            m_ready   = 1'b0;
        end
    endtask

    task automatic model_expect(output logic [3:0] an, output logic [6:0] seg, output logic fd);
        int         pos;
        int         dig;
        int         off;
        bit         shown;
        logic [3:0] h;
        an  = 4'hF;
        seg = 7'h7F;
        fd  = 1'b0;
        if (m_running) begin
            pos   = m_t % FRAME;
            dig   = pos / SLOT;
            off   = pos % SLOT;
            shown = 1'b1;
`ifdef SEG_LZ_BLANK_EN
            shown = (dig == 0) || ((m_shadow >> (4 * dig)) != 16'h0);
`endif
            h = 4'(m_shadow >> (4 * dig));
            if (shown) begin
                seg = seg_tab[h];
                if (off >= B) an = ~(4'b0001 << dig);
            end
            fd = (m_t > 0) && (pos == 0);
        end
    endtask

    task automatic check_outputs();
        logic [3:0] ea;
        logic [6:0] es;
        logic       ef;
        model_expect(ea, es, ef);
        check_val("an_out", 32'(an_out), 32'(ea));
        check_val("seg_out", 32'(seg_out), 32'(es));
        check_val("frame_done", 32'(frame_done), 32'(ef));
        check_val("load_ready", 32'(load_ready), 32'(m_ready));
    endtask

    task automatic cycle();
        @(posedge clk_in);
        if (rst) model_reset();
        else model_step();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_to_pos(input int target, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 4 * FRAME && !hit; i++) begin
            if (m_running && (m_t % FRAME == target)) hit = 1'b1;
            else cycle();
        end
        if (!hit) check_val({"wait_", tag}, 32'd0, 32'd1);
    endtask

    task automatic load_one(input logic [15:0] v);
        load_valid = 1'b1;
        data_in    = v;
        cycle();
        load_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_outputs();
        run(2);
        rst = 1'b0;
        run(2);

        // Load while idle, then scan 12AF for two frames.
        load_one(16'h12AF);
        enable = 1'b1;
        run(2 * FRAME);

        // Load during digit1 SHOW; a second offer while not ready must be ignored.
        run_to_pos(SLOT + B + 2, "d1show");
        load_one(16'h0003);
        load_one(16'hBEEF);
        run(2 * FRAME);

        load_one(16'h0070);
        run(2 * FRAME);
        load_one(16'h0000);
        run(2 * FRAME);
        load_one(16'h12AF);
        run(FRAME);

        // Drop enable during digit2 SHOW, then re-enable.
        run_to_pos(2 * SLOT + B + 3, "d2show");
        enable = 1'b0;
        run(5);
        enable = 1'b1;
        run(FRAME + 5);

        // Asynchronous reset between clock edges during a SHOW slot.
        run_to_pos(SLOT + B + 4, "rstshow");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #2 rst = 1'b0;
        run(FRAME + 3);

        for (int i = 0; i < 3000; i++) begin
            load_valid = ($urandom_range(0, 9) == 0);
            data_in    = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
